sub_layer_seq: RTL and testbench
================================

SUB_LAYER_SEQ -- requirements
Module: sub_layer_seq

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port clk_en, input, 1, clock enable; when low, every register including counter, FSM, result and done holds its value.
REQ-004 SHALL have port start, input, 1, one-cycle command strobe.
REQ-005 SHALL have port n, input, 2, opcode: 0=SUB, 1=READ_HI, 2=INV, 3=reserved.
REQ-006 SHALL have port dataa, input, 32, state bits [31:0].
REQ-007 SHALL have port datab, input, 32, state bits [63:32].
REQ-008 SHALL have port result, output, 32, registered command result.
REQ-009 SHALL have port done, output, 1, registered one-cycle completion pulse.

Function
REQ-010 SHALL use forward S-box S[0..F] = C,9,D,2,5,F,3,6,7,E,0,1,A,4,B,8.
REQ-011 SHALL use inverse S-box Si[0..F] = A,B,3,6,D,4,7,8,F,1,C,E,0,2,9,5.
REQ-012 SHALL implement FSM states IDLE, RUN, FIN; every transition is qualified by clk_en=1.
REQ-013 IDLE with start=1 and n=0 or n=2 SHALL load state={datab,dataa}, latch the mode (fwd/inv), clear the 4-bit nibble counter, and go to RUN.
REQ-014 In RUN, each enabled cycle SHALL replace nibble[cnt] (bits 4cnt+3:4cnt) with S or Si of itself, then increment cnt; nibble 0 is processed first.
REQ-015 RUN SHALL go to FIN on the cycle that processes nibble 15; cnt wraps 15->0 and is not used again until the next load.
REQ-016 In FIN, the design SHALL drive result=state[31:0] and done=1 for one enabled cycle, then return to IDLE.
REQ-017 SUB/INV latency SHALL be 17 enabled cycles: start sampled at edge k, done high after edge k+17.
REQ-018 IDLE with start=1 and n=1 SHALL drive result=state[63:32] of the last completed SUB/INV and done=1 after the next enabled edge; state is unchanged.
REQ-019 IDLE with start=1 and n=3 SHALL drive result=0 and done=1 after the next enabled edge; state is unchanged.
REQ-020 start while in RUN or FIN SHALL be ignored with no queuing.
REQ-021 done SHALL be low in every cycle other than the pulse cycle; result SHALL hold its value until the next pulse overwrites it.
REQ-022 When clk_en is low during RUN, substitution SHALL pause, and the pulse SHALL be extended only by the number of disabled cycles.
REQ-023 dataa and datab SHALL be sampled only on the start cycle; later changes to them have no effect.

Reset
REQ-024 reset_n=0 SHALL immediately force FSM=IDLE, cnt=0, state=0, mode=fwd, result=0, done=0, regardless of clk or clk_en.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; a following READ_HI SHALL return 0x00000000.
REQ-026 After reset_n is released, the first enabled edge with start=1 SHALL be accepted.

Verification
REQ-027 SUB with dataa=0x00000000, datab=0x00000000 -> done at edge k+17, result=0xCCCCCCCC; then READ_HI -> result=0xCCCCCCCC after 1 cycle.
REQ-028 SUB with dataa=0x76543210, datab=0xFEDCBA98 -> result=0x63F52D9C; then READ_HI -> 0x8B4A10E7.
REQ-029 INV with dataa=0x63F52D9C, datab=0x8B4A10E7 -> result=0x76543210; then READ_HI -> 0xFEDCBA98 (round-trip).
REQ-030 SUB with clk_en held low for 5 cycles mid-RUN, plus a second start pulse during RUN -> done at edge k+22, single pulse, result unchanged from REQ-028.
REQ-031 reset_n pulsed low at RUN cycle 8 -> done stays 0, result=0; then n=3 start -> result=0, done pulse after 1 cycle.

Source files
------------

// File: rtl/sub_layer_seq.sv
// sub_layer_seq: nibble-serial 4-bit S-box layer over a 64-bit state.
// Ports: clk, reset_n, clk_en, start, n[1:0], dataa, datab -> result, done.
//
// One nibble of the 64-bit state is substituted per enabled cycle,
// starting at nibble 0. A command takes 17 enabled cycles from the
// start edge to the done pulse: 16 substitution cycles plus 1 finish
// cycle. The state is kept after the command so that READ_HI can
// return its upper word.
//
// Opcodes on n: 0 = SUB (forward S-box), 1 = READ_HI,
// 2 = INV (inverse S-box), 3 = reserved (result 0).
// When clk_en is low every register holds its value.
module sub_layer_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [1:0] OP_SUB  = 2'd0;
  localparam logic [1:0] OP_RDHI = 2'd1;
  localparam logic [1:0] OP_INV  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic [1:0]  fsm_q, fsm_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] state_q, state_d;
  logic        inv_q, inv_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  logic [63:0] state_sub;

  function automatic logic [3:0] sbox_fwd(
    input logic [3:0] x
  );
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h9;
      4'h2: y = 4'hD;
      4'h3: y = 4'h2;
      4'h4: y = 4'h5;
      4'h5: y = 4'hF;
      4'h6: y = 4'h3;
      4'h7: y = 4'h6;
      4'h8: y = 4'h7;
      4'h9: y = 4'hE;
      4'hA: y = 4'h0;
      4'hB: y = 4'h1;
      4'hC: y = 4'hA;
      4'hD: y = 4'h4;
      4'hE: y = 4'hB;
      4'hF: y = 4'h8;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(
    input logic [3:0] x
  );
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hA;
      4'h1: y = 4'hB;
      4'h2: y = 4'h3;
      4'h3: y = 4'h6;
      4'h4: y = 4'hD;
      4'h5: y = 4'h4;
      4'h6: y = 4'h7;
      4'h7: y = 4'h8;
      4'h8: y = 4'hF;
      4'h9: y = 4'h1;
      4'hA: y = 4'hC;
      4'hB: y = 4'hE;
      4'hC: y = 4'h0;
      4'hD: y = 4'h2;
      4'hE: y = 4'h9;
      4'hF: y = 4'h5;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  // State with only the nibble selected by cnt_q substituted.
  always_comb begin
    state_sub = state_q;
    for (int i = 0; i < 16; i++) begin
      if (cnt_q == 4'(i)) begin
        if (inv_q) begin
          state_sub[4*i +: 4] = sbox_inv(state_q[4*i +: 4]);
        end else begin
          state_sub[4*i +: 4] = sbox_fwd(state_q[4*i +: 4]);
        end
      end
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    inv_d    = inv_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          unique case (n)
            OP_SUB, OP_INV: begin
              state_d = {datab, dataa};
              inv_d   = (n == OP_INV);
              cnt_d   = 4'd0;
              fsm_d   = S_RUN;
            end
            OP_RDHI: begin
              result_d = state_q[63:32];
              done_d   = 1'b1;
            end
            OP_RSVD: begin
              result_d = 32'd0;
              done_d   = 1'b1;
            end
            default: begin
              done_d = 1'b0;
            end
          endcase
        end
      end
      S_RUN: begin
        state_d = state_sub;
        // Wraps 15 -> 0; harmless since FIN ignores it.
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          fsm_d = S_FIN;
        end
      end
      S_FIN: begin
        result_d = state_q[31:0];
        done_d   = 1'b1;
        fsm_d    = S_IDLE;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q    <= S_IDLE;
      cnt_q    <= 4'd0;
      state_q  <= 64'd0;
      inv_q    <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      inv_q    <= inv_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sub_layer_seq.sv
// tb_sub_layer_seq: self-checking bench for sub_layer_seq.
// Tasks per scenario, reference model kept as a plain 64-bit state.
module tb_sub_layer_seq;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [1:0]  n;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: last completed 64-bit state.
  logic [63:0] m_state;

  int SF [16] = '{12, 9, 13, 2, 5, 15, 3, 6,
                  7, 14, 0, 1, 10, 4, 11, 8};
  int SI [16] = '{10, 11, 3, 6, 13, 4, 7, 8,
                  15, 1, 12, 14, 0, 2, 9, 5};

  sub_layer_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .n       (n),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] subst(
    input logic [63:0] s,
    input bit          inv
  );
    logic [63:0] r;
    int v;
    r = s;
    for (int i = 0; i < 16; i++) begin
      v = int'(s[4*i +: 4]);
      r[4*i +: 4] = inv ? 4'(SI[v]) : 4'(SF[v]);
    end
    return r;
  endfunction

  // Presents one start pulse; returns at the negedge after the
  // sampling edge.
  task automatic issue(
    input logic [1:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    @(negedge clk);
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    @(negedge clk);
    start = 1'b0;
    n     = 2'($urandom);
    dataa = $urandom;
    datab = $urandom;
  endtask

  // lat = enabled edges after the sampling edge until done seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    int lat;
    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    n       = 2'd0;
    dataa   = 32'd0;
    datab   = 32'd0;
    m_state = 64'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (result !== 32'd0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state result=%h done=%b want 0/0",
               result, done);
    end
    // First edge after release carries a READ_HI.
    reset_n = 1'b1;
    start   = 1'b1;
    n       = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    n_checks++;
    if (done !== 1'b1 || lat != 0 || result !== 32'd0) begin
      n_errors++;
      $display("FAIL first_start done=%b lat=%0d res=%h want 1/0/0",
               done, lat, result);
    end
  endtask

  task automatic run_op(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  string       name,
    input  logic [31:0] want
  );
    int lat;
    int want_lat;
    want_lat = (op == 2'd0 || op == 2'd2) ? 17 : 0;
    issue(op, a, b);
    wait_done(lat);
    n_checks++;
    if (done !== 1'b1 || lat != want_lat || result !== want) begin
      n_errors++;
      $display("FAIL %s done=%b lat=%0d res=%h want lat=%0d res=%h",
               name, done, lat, result, want_lat, want);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result !== want) begin
      n_errors++;
      $display("FAIL %s_after done=%b res=%h want 0/%h",
               name, done, result, want);
    end
  endtask

  task automatic test_vectors;
    run_op(2'd0, 32'h0, 32'h0, "sub_zero", 32'hCCCCCCCC);
    run_op(2'd1, 32'h0, 32'h0, "rdhi_zero", 32'hCCCCCCCC);
    run_op(2'd0, 32'h76543210, 32'hFEDCBA98, "sub_vec",
           32'h63F52D9C);
    run_op(2'd1, 32'h0, 32'h0, "rdhi_vec", 32'h8B4A10E7);
    run_op(2'd2, 32'h63F52D9C, 32'h8B4A10E7, "inv_vec",
           32'h76543210);
    run_op(2'd1, 32'h0, 32'h0, "rdhi_inv", 32'hFEDCBA98);
    run_op(2'd3, 32'h0, 32'h0, "reserved", 32'h0);
    m_state = 64'hFEDCBA98_76543210;
  endtask

  task automatic test_pause_and_ignore;
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    issue(2'd0, 32'h76543210, 32'hFEDCBA98);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      clk_en = !(cyc >= 5 && cyc <= 9);
      start  = (cyc == 12);
      n      = 2'd0;
      dataa  = $urandom;
      datab  = $urandom;
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    clk_en = 1'b1;
    start  = 1'b0;
    m_state = subst(64'hFEDCBA98_76543210, 1'b0);
    n_checks++;
    if (first != 22 || pulses != 1) begin
      n_errors++;
      $display("FAIL pause_timing first=%0d pulses=%0d want 22/1",
               first, pulses);
    end
    n_checks++;
    if (result !== 32'h63F52D9C) begin
      n_errors++;
      $display("FAIL pause_result res=%h want 63f52d9c", result);
    end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    pulses = 0;
    issue(2'd0, $urandom, $urandom);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      n_errors++;
      $display("FAIL async_reset done=%b res=%h want 0/0",
               done, result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_state = 64'd0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL abort_no_done pulses=%0d want 0", pulses);
    end
    run_op(2'd1, 32'h0, 32'h0, "rdhi_after_rst", 32'h0);
    run_op(2'd3, 32'h0, 32'h0, "rsvd_after_rst", 32'h0);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] want;
    logic [31:0] held;
    for (int it = 0; it < 24; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      unique case (op)
        2'd0, 2'd2: begin
          m_state = subst({b, a}, op == 2'd2);
          want = m_state[31:0];
        end
        2'd1: want = m_state[63:32];
        default: want = 32'd0;
      endcase
      run_op(op, a, b, "random", want);
      held = want;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || result !== held) begin
        n_errors++;
        $display("FAIL hold it=%0d done=%b res=%h want 0/%h",
                 it, done, result, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_pause_and_ignore();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
